// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default parameters for the DMEM arbiter.
package dmem_arbiter_pkg;

  localparam int DEF_NCORES  = 4;
  localparam int DEF_AW      = 8;
  localparam int DEF_DW      = 8;
  localparam int DEF_MEM_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side request bus plus shared memory port. The arbiter is the slave;
// the cores and memory (or a bench standing in for them) use the master view.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int NCORES = DEF_NCORES,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW
);
  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    we;
  logic [NCORES*AW-1:0] addr;
  logic [NCORES*DW-1:0] wdata;
  logic [NCORES-1:0]    grant;
  logic [NCORES-1:0]    done;
  logic [DW-1:0]        rdata;
  logic                 busy;
  logic                 mem_en;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  grant, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output grant, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Rotating-priority encoder: the first requester at or after ptr wins,
// wrapping past N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  // Scan N candidates starting from ptr; keep the first one that requests.
  always_comb begin
    int c;
    c        = 0;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[c]) begin
        any_o       = 1'b1;
        idx_o       = PW'(c);
        onehot_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port DMEM among NCORES cores.
// One transaction: IDLE (pick) -> ISSUE (mem_en) -> WAIT x MEM_LAT -> DONE.
// Every output is a flop; next values are computed one state ahead.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NCORES  = DEF_NCORES,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int LW = $clog2(MEM_LAT + 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [NCORES-1:0] grant_q, grant_d;
  logic [NCORES-1:0] done_q, done_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;

  logic [NCORES-1:0] pick_onehot;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;

  rr_pick #(.N(NCORES), .PW(PW)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Mux the winning core's command fields using the one-hot pick.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (pick_onehot[i]) begin
        sel_we    = bus.we[i];
        sel_addr  = bus.addr[i*AW +: AW];
        sel_wdata = bus.wdata[i*DW +: DW];
      end
    end
  end

  // Next-state and next-output logic; mem_* registers double as the command latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    grant_d     = grant_q;
    done_d      = '0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d     = ST_ISSUE;
          idx_d       = pick_idx;
          grant_d     = pick_onehot;
          busy_d      = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        lat_d   = LW'(MEM_LAT);
      end
      ST_WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LW'(1)) begin
          state_d = ST_DONE;
          done_d  = grant_q;
          if (!mem_we_q) begin
            rdata_d = bus.mem_rdata;
          end
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        ptr_d       = (idx_q == PW'(NCORES - 1)) ? '0 : idx_q + 1'b1;
        grant_d     = '0;
        busy_d      = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      lat_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
